// File: rtl/vortex_ctrl_sequencer.sv
// vortex_ctrl_sequencer: AXI4-Lite master that launches one Vortex AFU kernel
// per command. It writes the argument registers, sets ap_start, polls ap_ctrl
// until ap_done (or a timeout), then returns a status on the rsp handshake.
//
// Build option VORTEX_CTRL_SEQ_IRQ_EN: adds the interrupt input. GIE and IER
// are written before the arguments, POLL_WAIT waits for interrupt instead of
// a fixed interval, and the ISR is cleared after done.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | ready for a command (cmd_rdy = 1)
// S_WR_ADDR   | AW and W issued together, each drops on its own handshake
// S_WR_RESP   | waiting for B; selects next write, polling or error
// S_POLL_WAIT | gap before the next status read (interval or interrupt)
// S_RD_ADDR   | AR to ap_ctrl outstanding
// S_RD_RESP   | waiting for R; done -> finish, else poll again
// S_RESP      | rsp_val held with a stable status until rsp_rdy
module vortex_ctrl_sequencer #(
  parameter int                ADDR_W        = 8,
  parameter int                DATA_W        = 32,
  parameter int                NUM_ARGS      = 4,
  parameter logic [ADDR_W-1:0] CTRL_ADDR     = 8'h00,
  parameter logic [ADDR_W-1:0] ARG_BASE      = 8'h10,
  parameter int                POLL_INTERVAL = 16,
  parameter int                TIMEOUT_W     = 24
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       cmd_val,
  output logic                       cmd_rdy,
  input  logic [NUM_ARGS*DATA_W-1:0] cmd_args,
  output logic                       rsp_val,
  input  logic                       rsp_rdy,
  output logic [1:0]                 rsp_status,
  output logic                       busy,
`ifdef VORTEX_CTRL_SEQ_IRQ_EN
  input  logic                       interrupt,
`endif
  output logic                       m_axi_ctrl_awvalid,
  input  logic                       m_axi_ctrl_awready,
  output logic [ADDR_W-1:0]          m_axi_ctrl_awaddr,
  output logic                       m_axi_ctrl_wvalid,
  input  logic                       m_axi_ctrl_wready,
  output logic [DATA_W-1:0]          m_axi_ctrl_wdata,
  output logic [DATA_W/8-1:0]        m_axi_ctrl_wstrb,
  input  logic                       m_axi_ctrl_bvalid,
  output logic                       m_axi_ctrl_bready,
  input  logic [1:0]                 m_axi_ctrl_bresp,
  output logic                       m_axi_ctrl_arvalid,
  input  logic                       m_axi_ctrl_arready,
  output logic [ADDR_W-1:0]          m_axi_ctrl_araddr,
  input  logic                       m_axi_ctrl_rvalid,
  output logic                       m_axi_ctrl_rready,
  input  logic [DATA_W-1:0]          m_axi_ctrl_rdata,
  input  logic [1:0]                 m_axi_ctrl_rresp
);

`ifdef VORTEX_CTRL_SEQ_IRQ_EN
  localparam int PRE_WR = 2;
`else
  localparam int PRE_WR = 0;
`endif
  // Write steps: [GIE, IER,] args 0..NUM_ARGS-1, ap_start, [ISR clear]
  localparam int START_STEP = PRE_WR + NUM_ARGS;
  localparam int ISR_STEP   = START_STEP + 1;
  localparam int STEP_W     = $clog2(ISR_STEP + 1);
  localparam int PCNT_W     = $clog2(POLL_INTERVAL + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_RESP, S_POLL_WAIT, S_RD_ADDR, S_RD_RESP, S_RESP
  } state_t;

  state_t                     state_q, state_d;
  logic [STEP_W-1:0]          step_q, step_d;
  logic                       awv_q, awv_d, wv_q, wv_d, arv_q, arv_d;
  logic [1:0]                 status_q, status_d;
  logic [TIMEOUT_W-1:0]       tmo_q, tmo_d;
  logic [PCNT_W-1:0]          pcnt_q, pcnt_d;
  logic [NUM_ARGS*DATA_W-1:0] args_q, args_d;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       tmo_sat;
  int                         arg_i;
  logic                       unused_rdata;

  assign tmo_sat      = &tmo_q;
  assign unused_rdata = ^{m_axi_ctrl_rdata[DATA_W-1:2], m_axi_ctrl_rdata[0]};

  // Decode the current write step into its target register and data word
  always_comb begin
    arg_i   = int'(step_q) - PRE_WR;
    wr_addr = CTRL_ADDR;
    wr_data = DATA_W'(1);
    if (arg_i >= 0 && arg_i < NUM_ARGS) begin
      wr_addr = ARG_BASE + ADDR_W'(4 * arg_i);
      wr_data = args_q[arg_i*DATA_W +: DATA_W];
    end
`ifdef VORTEX_CTRL_SEQ_IRQ_EN
    else if (step_q == STEP_W'(0)) wr_addr = ADDR_W'(8'h04);
    else if (step_q == STEP_W'(1)) wr_addr = ADDR_W'(8'h08);
    else if (int'(step_q) == ISR_STEP) wr_addr = ADDR_W'(8'h0C);
`endif
  end

  // Next-state, channel valids, timers and status
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    awv_d    = awv_q;
    wv_d     = wv_q;
    arv_d    = arv_q;
    status_d = status_q;
    tmo_d    = tmo_q;
    pcnt_d   = pcnt_q;
    args_d   = args_q;
    if ((state_q inside {S_POLL_WAIT, S_RD_ADDR, S_RD_RESP}) && !tmo_sat)
      tmo_d = tmo_q + 1'b1;
    case (state_q)
      S_IDLE: if (cmd_val) begin
        args_d  = cmd_args;
        step_d  = '0;
        awv_d   = 1'b1;
        wv_d    = 1'b1;
        state_d = S_WR_ADDR;
      end
      S_WR_ADDR: begin
        if (awv_q && m_axi_ctrl_awready) awv_d = 1'b0;
        if (wv_q && m_axi_ctrl_wready)   wv_d  = 1'b0;
        if (!awv_d && !wv_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: if (m_axi_ctrl_bvalid) begin
        if (m_axi_ctrl_bresp != 2'b00) begin
          status_d = 2'b01;
          state_d  = S_RESP;
        end else if (int'(step_q) < START_STEP) begin
          step_d  = step_q + 1'b1;
          awv_d   = 1'b1;
          wv_d    = 1'b1;
          state_d = S_WR_ADDR;
        end else if (int'(step_q) == START_STEP) begin
          tmo_d   = '0;
          pcnt_d  = PCNT_W'(POLL_INTERVAL - 1);
          state_d = S_POLL_WAIT;
        end else begin
          // ISR clear completed
          status_d = 2'b00;
          state_d  = S_RESP;
        end
      end
      S_POLL_WAIT: begin
        if (tmo_sat) begin
          status_d = 2'b10;
          state_d  = S_RESP;
        end
`ifdef VORTEX_CTRL_SEQ_IRQ_EN
        else if (interrupt) begin
          arv_d   = 1'b1;
          state_d = S_RD_ADDR;
        end
`else
        else if (pcnt_q == '0) begin
          arv_d   = 1'b1;
          state_d = S_RD_ADDR;
        end else begin
          pcnt_d = pcnt_q - 1'b1;
        end
`endif
      end
      S_RD_ADDR: if (m_axi_ctrl_arready) begin
        arv_d   = 1'b0;
        state_d = S_RD_RESP;
      end
      S_RD_RESP: if (m_axi_ctrl_rvalid) begin
        if (m_axi_ctrl_rresp != 2'b00) begin
          status_d = 2'b01;
          state_d  = S_RESP;
        end else if (m_axi_ctrl_rdata[1]) begin
`ifdef VORTEX_CTRL_SEQ_IRQ_EN
          step_d  = STEP_W'(ISR_STEP);
          awv_d   = 1'b1;
          wv_d    = 1'b1;
          state_d = S_WR_ADDR;
`else
          status_d = 2'b00;
          state_d  = S_RESP;
`endif
        end else begin
          pcnt_d  = PCNT_W'(POLL_INTERVAL - 1);
          state_d = S_POLL_WAIT;
        end
      end
      S_RESP: if (rsp_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      awv_q    <= 1'b0;
      wv_q     <= 1'b0;
      arv_q    <= 1'b0;
      status_q <= 2'b00;
      tmo_q    <= '0;
      pcnt_q   <= '0;
      args_q   <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      awv_q    <= awv_d;
      wv_q     <= wv_d;
      arv_q    <= arv_d;
      status_q <= status_d;
      tmo_q    <= tmo_d;
      pcnt_q   <= pcnt_d;
      args_q   <= args_d;
    end
  end

  // cmd_rdy is gated by reset so it reads 0 while reset is held
  assign cmd_rdy            = (state_q == S_IDLE) && sys_rst_n;
  assign busy               = (state_q != S_IDLE);
  assign rsp_val            = (state_q == S_RESP);
  assign rsp_status         = status_q;
  assign m_axi_ctrl_awvalid = awv_q;
  assign m_axi_ctrl_awaddr  = awv_q ? wr_addr : '0;
  assign m_axi_ctrl_wvalid  = wv_q;
  assign m_axi_ctrl_wdata   = wv_q ? wr_data : '0;
  assign m_axi_ctrl_wstrb   = '1;
  assign m_axi_ctrl_bready  = (state_q == S_WR_RESP);
  assign m_axi_ctrl_arvalid = arv_q;
  assign m_axi_ctrl_araddr  = arv_q ? CTRL_ADDR : '0;
  assign m_axi_ctrl_rready  = (state_q == S_RD_RESP);

endmodule

// File: tb/tb_vortex_ctrl_sequencer.sv
// Testbench for vortex_ctrl_sequencer: AXI4-Lite slave model, expected-value
// queues filled by the stimulus, and a monitor that compares on each write
// pair, status read and completion.
module tb_vortex_ctrl_sequencer;
  localparam int NA = 4;
  localparam int PI = 16;

  logic          sys_clk, sys_rst_n;
  logic          cmd_val, cmd_rdy, rsp_val, rsp_rdy, busy;
  logic [NA*32-1:0] cmd_args;
  logic [1:0]    rsp_status;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [7:0]    awaddr, araddr;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
`ifdef VORTEX_CTRL_SEQ_IRQ_EN
  logic          interrupt;
`endif

  vortex_ctrl_sequencer #(.NUM_ARGS(NA), .POLL_INTERVAL(PI), .TIMEOUT_W(6)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_args(cmd_args),
    .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_status(rsp_status), .busy(busy),
`ifdef VORTEX_CTRL_SEQ_IRQ_EN
    .interrupt(interrupt),
`endif
    .m_axi_ctrl_awvalid(awvalid), .m_axi_ctrl_awready(awready), .m_axi_ctrl_awaddr(awaddr),
    .m_axi_ctrl_wvalid(wvalid), .m_axi_ctrl_wready(wready), .m_axi_ctrl_wdata(wdata),
    .m_axi_ctrl_wstrb(wstrb),
    .m_axi_ctrl_bvalid(bvalid), .m_axi_ctrl_bready(bready), .m_axi_ctrl_bresp(bresp),
    .m_axi_ctrl_arvalid(arvalid), .m_axi_ctrl_arready(arready), .m_axi_ctrl_araddr(araddr),
    .m_axi_ctrl_rvalid(rvalid), .m_axi_ctrl_rready(rready), .m_axi_ctrl_rdata(rdata),
    .m_axi_ctrl_rresp(rresp)
  );

  typedef struct { logic [7:0] addr; logic [31:0] data; int aw_cyc; int w_cyc; } wr_exp_t;
  typedef struct { logic [1:0] status; int nwr; int nrd; int lat; } rsp_exp_t;
  wr_exp_t  exp_wr[$];
  rsp_exp_t exp_rsp[$];
  int n_cmp = 0;
  int n_err = 0;

  // slave configuration, written only by the stimulus
  int aw_delay = 0;
  int bad_wr   = -1;
  int done_rd  = 0;
  int bad_rd   = 0;

  initial begin
    sys_clk = 0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- AXI4-Lite slave model ----------------
  initial begin
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, cmd_hs, aw_got, w_got;
    int aw_cnt, wr_num, rd_num;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 1; rvalid = 0; rdata = 0; rresp = 0;
    aw_got = 0; w_got = 0; aw_cnt = 0; wr_num = 0; rd_num = 0;
    forever begin
      @(negedge sys_clk);
      aw_hs = awvalid & awready; w_hs = wvalid & wready; b_hs = bvalid & bready;
      ar_hs = arvalid & arready; r_hs = rvalid & rready; cmd_hs = cmd_val & cmd_rdy;
      @(posedge sys_clk);
      #1;
      if (!sys_rst_n) begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        rvalid = 0; rdata = 0; rresp = 0; aw_got = 0; w_got = 0; aw_cnt = 0;
      end else begin
        if (cmd_hs) begin wr_num = 0; rd_num = 0; end
        if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin awready = 0; aw_cnt = 0; end
        wready = wvalid;
        if (aw_hs) aw_got = 1;
        if (w_hs)  w_got  = 1;
        if (b_hs) begin bvalid = 0; bresp = 0; end
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0; bvalid = 1;
          bresp = (wr_num == bad_wr) ? 2'b10 : 2'b00;
          wr_num++;
        end
        if (r_hs) begin rvalid = 0; rdata = 0; rresp = 0; end
        if (ar_hs) begin
          rd_num++;
          rvalid = 1;
          rdata  = (rd_num == done_rd) ? 32'h2 : 32'h0;
          rresp  = (rd_num == bad_rd) ? 2'b11 : 2'b00;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int cyc, aw_cyc, w_cyc, cur_aw, cur_w, cmd_wr, cmd_b, cmd_rd, ar_out;
    int last_ar, last_b, rsp_start;
    logic aw_seen, w_seen, rsp_prev;
    logic [7:0] cur_addr;
    logic [31:0] cur_data;
    wr_exp_t we;
    rsp_exp_t re;
    cyc = 0; aw_cyc = 0; w_cyc = 0; cur_aw = 0; cur_w = 0; cmd_wr = 0; cmd_b = 0;
    cmd_rd = 0; ar_out = 0; last_ar = 0; last_b = 0; rsp_start = 0;
    aw_seen = 0; w_seen = 0; rsp_prev = 0; cur_addr = 0; cur_data = 0;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (!sys_rst_n) begin
        aw_cyc = 0; w_cyc = 0; cmd_wr = 0; cmd_b = 0; cmd_rd = 0; ar_out = 0;
        aw_seen = 0; w_seen = 0; rsp_prev = 0;
      end else begin
        if (awvalid) aw_cyc++;
        if (wvalid)  w_cyc++;
        if (awvalid & awready) begin cur_addr = awaddr; cur_aw = aw_cyc; aw_cyc = 0; aw_seen = 1; end
        if (wvalid & wready) begin cur_data = wdata; cur_w = w_cyc; w_cyc = 0; w_seen = 1; end
        if (aw_seen && w_seen) begin
          aw_seen = 0; w_seen = 0; cmd_wr++;
          if (exp_wr.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL wr_unexpected: got write %0h=%0h expected none", cur_addr, cur_data);
          end else begin
            we = exp_wr.pop_front();
            chk("wr_addr", 32'(cur_addr), 32'(we.addr));
            chk("wr_data", cur_data, we.data);
            chk("aw_valid_cycles", cur_aw, we.aw_cyc);
            chk("w_valid_cycles", cur_w, we.w_cyc);
          end
        end
        if (bvalid & bready) begin cmd_b++; last_b = cyc; end
        if (arvalid & arready) begin
          chk("araddr", 32'(araddr), 32'h0);
`ifndef VORTEX_CTRL_SEQ_IRQ_EN
          if (cmd_rd > 0) chk("poll_gap", cyc - last_ar, PI + 2);
`endif
          last_ar = cyc; cmd_rd++; ar_out++;
        end
        if (rvalid & rready) ar_out--;
        if (rsp_val && !rsp_prev) rsp_start = cyc;
        rsp_prev = rsp_val;
        if (rsp_val & rsp_rdy) begin
          if (exp_rsp.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rsp_unexpected: got status %0d expected no response", rsp_status);
          end else begin
            re = exp_rsp.pop_front();
            chk("rsp_status", 32'(rsp_status), 32'(re.status));
            chk("num_writes", cmd_wr, re.nwr);
            chk("num_b", cmd_b, re.nwr);
            chk("num_reads", cmd_rd, re.nrd);
            chk("ar_outstanding", ar_out, 0);
            if (re.lat >= 0) chk("rsp_latency", rsp_start - last_b, re.lat);
          end
          cmd_wr = 0; cmd_b = 0; cmd_rd = 0; ar_out = 0; rsp_prev = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_wr(input logic [7:0] a, input logic [31:0] d, input int awc);
    wr_exp_t e;
    e.addr = a; e.data = d; e.aw_cyc = awc; e.w_cyc = 1;
    exp_wr.push_back(e);
  endtask

  task automatic push_args(input logic [NA*32-1:0] a, input int n, input int awc);
    for (int i = 0; i < n; i++) push_wr(8'h10 + 8'(4 * i), a[32*i +: 32], awc);
  endtask

  task automatic push_rsp(input logic [1:0] st, input int nwr, input int nrd, input int lat);
    rsp_exp_t e;
    e.status = st; e.nwr = nwr; e.nrd = nrd; e.lat = lat;
    exp_rsp.push_back(e);
  endtask

  task automatic issue(input logic [NA*32-1:0] a);
    int n;
    @(posedge sys_clk); #1;
    cmd_args = a; cmd_val = 1;
    n = 0;
    do begin @(negedge sys_clk); n++; end while (!cmd_rdy && n < 100);
    chk("cmd_accept", 32'(cmd_rdy), 32'h1);
    @(posedge sys_clk); #1;
    cmd_val = 0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    do begin @(negedge sys_clk); n++; end while (!(rsp_val && rsp_rdy) && n < 1000);
    if (!(rsp_val && rsp_rdy)) begin
      n_cmp++; n_err++;
      $display("FAIL rsp_wait: got no completion expected one within 1000 cycles");
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cmd_rdy"}, 32'(cmd_rdy), 0);
    chk({tag, "_busy"},    32'(busy), 0);
    chk({tag, "_rsp_val"}, 32'(rsp_val), 0);
    chk({tag, "_awvalid"}, 32'(awvalid), 0);
    chk({tag, "_wvalid"},  32'(wvalid), 0);
    chk({tag, "_arvalid"}, 32'(arvalid), 0);
    chk({tag, "_bready"},  32'(bready), 0);
    chk({tag, "_rready"},  32'(rready), 0);
    chk({tag, "_wdata"},   wdata, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [NA*32-1:0] a;
    int n;
    sys_rst_n = 0; cmd_val = 0; rsp_rdy = 1; cmd_args = '0;
`ifdef VORTEX_CTRL_SEQ_IRQ_EN
    interrupt = 0;
`endif
    repeat (3) @(negedge sys_clk);
    chk_quiet("reset");
    chk("reset_status", 32'(rsp_status), 0);
    chk("wstrb", 32'(wstrb), 32'hF);
    sys_rst_n = 1;
    @(negedge sys_clk);
    chk("idle_cmd_rdy", 32'(cmd_rdy), 1);

`ifndef VORTEX_CTRL_SEQ_IRQ_EN
    // args {4,3,2,1}, done on third read
    a = {32'd4, 32'd3, 32'd2, 32'd1};
    done_rd = 3;
    push_args(a, NA, 1); push_wr(8'h00, 32'h1, 1);
    push_rsp(2'b00, 5, 3, 55);
    issue(a); wait_rsp();

    // awready delayed 3 cycles, done on first read
    a = {32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5, 32'h0F0F0F0F};
    aw_delay = 3; done_rd = 1;
    push_args(a, NA, 4); push_wr(8'h00, 32'h1, 4);
    push_rsp(2'b00, 5, 1, 19);
    issue(a); wait_rsp();
    aw_delay = 0;

    // bresp SLVERR on arg 2: no further writes
    a = {32'h44, 32'h33, 32'h22, 32'h11};
    bad_wr = 2;
    push_args(a, 3, 1);
    push_rsp(2'b01, 3, 0, 1);
    issue(a); wait_rsp();
    bad_wr = -1;

    // rresp DECERR on the second poll
    a = {32'h8, 32'h7, 32'h6, 32'h5};
    done_rd = 0; bad_rd = 2;
    push_args(a, NA, 1); push_wr(8'h00, 32'h1, 1);
    push_rsp(2'b01, 5, 2, 37);
    issue(a); wait_rsp();
    bad_rd = 0;

    // done never set: timeout after the 6-bit counter saturates
    a = {32'hC, 32'hB, 32'hA, 32'h9};
    push_args(a, NA, 1); push_wr(8'h00, 32'h1, 1);
    push_rsp(2'b10, 5, 3, 65);
    issue(a); wait_rsp();
    chk("timeout_arvalid", 32'(arvalid), 0);

    // rsp_rdy held low: response must hold still
    a = {32'h1, 32'h2, 32'h3, 32'h4};
    rsp_rdy = 0; bad_wr = 0;
    push_args(a, 1, 1);
    push_rsp(2'b01, 1, 0, 1);
    issue(a);
    n = 0;
    do begin @(negedge sys_clk); n++; end while (!rsp_val && n < 200);
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      chk("hold_rsp_val", 32'(rsp_val), 1);
      chk("hold_rsp_status", 32'(rsp_status), 32'h1);
      chk("hold_cmd_rdy", 32'(cmd_rdy), 0);
    end
    @(posedge sys_clk); #1;
    rsp_rdy = 1; bad_wr = -1;
    wait_rsp();

    // reset pulsed while in POLL_WAIT
    a = {32'h99, 32'h88, 32'h77, 32'h66};
    done_rd = 1;
    push_args(a, NA, 1); push_wr(8'h00, 32'h1, 1);
    push_rsp(2'b00, 5, 1, 19);
    issue(a);
    n = 0;
    for (int k = 0; k < 300 && n < NA + 1; k++) begin
      @(negedge sys_clk);
      if (bvalid && bready) n++;
    end
    repeat (3) @(negedge sys_clk);
    chk("poll_busy", 32'(busy), 1);
    #1 sys_rst_n = 0;
    #1 chk_quiet("rst_mid");
    exp_rsp.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1;
    @(negedge sys_clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_cmd_rdy", 32'(cmd_rdy), 1);

    // recovery command, done on second read
    a = {32'h5555, 32'h4444, 32'h3333, 32'h2222};
    done_rd = 2;
    push_args(a, NA, 1); push_wr(8'h00, 32'h1, 1);
    push_rsp(2'b00, 5, 2, 37);
    issue(a); wait_rsp();
`else
    // interrupt 50 cycles after launch: GIE, IER, args, start, one read, ISR
    a = {32'd4, 32'd3, 32'd2, 32'd1};
    done_rd = 1;
    push_wr(8'h04, 32'h1, 1); push_wr(8'h08, 32'h1, 1);
    push_args(a, NA, 1); push_wr(8'h00, 32'h1, 1); push_wr(8'h0C, 32'h1, 1);
    push_rsp(2'b00, NA + 4, 1, 1);
    issue(a);
    repeat (50) @(posedge sys_clk);
    #1 interrupt = 1;
    wait_rsp();
    interrupt = 0;

    // no interrupt: timeout without any status read
    a = {32'h8, 32'h7, 32'h6, 32'h5};
    done_rd = 0;
    push_wr(8'h04, 32'h1, 1); push_wr(8'h08, 32'h1, 1);
    push_args(a, NA, 1); push_wr(8'h00, 32'h1, 1);
    push_rsp(2'b10, NA + 3, 0, 65);
    issue(a); wait_rsp();
`endif

    repeat (3) @(negedge sys_clk);
    chk("exp_rsp_left", exp_rsp.size(), 0);
    chk("exp_wr_left", exp_wr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
